ring_injector: RTL and testbench

- Per-cell injection buffer between a cell's force-evaluation pipeline (PE) and its ring node PE port.
- Accepts force records tagged with a destination cell.
- Packs them into ring packets {dest_id, particle_id, force} and buffers them in a circular FIFO.
- Presents packets to the ring under a valid/ready handshake, and tracks phase drain for the motion-update controller.

---
 rtl/ring_injector.sv | 147 ++++++++++++++
 tb/tb_ring_injector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_injector.sv
// ring_injector: per-cell force-record injection buffer.
// Packs PE force records into ring packets and meters the phase drain.
module ring_injector #(
    parameter int NUM_CELLS         = 64,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
    parameter int FIFO_DEPTH        = 16,
    parameter int CNT_WIDTH         = 16,
    localparam int FORCE_WIDTH      = 3 * DATA_WIDTH,
    localparam int PKT_WIDTH        =
        NODE_ID_WIDTH + PARTICLE_ID_WIDTH + FORCE_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         phase_start,
    input  logic                         phase_end,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NODE_ID_WIDTH-1:0]     in_dest,
    input  logic [PARTICLE_ID_WIDTH-1:0] in_pid,
    input  logic [FORCE_WIDTH-1:0]       in_force,
    output logic [PKT_WIDTH-1:0]         pkt_out,
    output logic                         pkt_valid,
    input  logic                         ring_ready,
    output logic                         drain_done,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         sent_count
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CW        = PTR_WIDTH + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SENT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SENT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    logic [PKT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]        count;

    logic push;
    logic pop;
    logic start_ok;

    // Accept only while collecting and not full; no pop-enabled push.
    assign in_ready = (state == ACTIVE) && (count != FULL_CNT);
    assign push     = in_valid && in_ready;

    // Show-ahead head; zero when empty so nothing stale is exposed.
    assign pkt_valid = (count != '0);
    assign pkt_out   = pkt_valid ? mem[rd_ptr] : '0;
    assign pop       = pkt_valid && ring_ready;

    // A phase may only open from IDLE; start elsewhere is ignored.
    assign start_ok = (state == IDLE) && phase_start;

    // Phase control with registered busy and drain_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (phase_start) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (phase_end) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == '0) begin
                        state      <= DONE;
                        drain_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Packet storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_dest, in_pid, in_force};
        end
    end

    // Circular pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of packets taken by the ring this phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_count <= '0;
        end else if (start_ok) begin
            sent_count <= '0;
        end else if (pop && (sent_count != SENT_MAX)) begin
            sent_count <= sent_count + SENT_ONE;
        end
    end

endmodule

// File: tb/tb_ring_injector.sv
// tb_ring_injector: directed stimulus, queue-based reference model.
// Compares all outputs every cycle and pins key points with literals.
module tb_ring_injector;

    localparam int NW  = 6;
    localparam int PIW = 7;
    localparam int FW  = 96;
    localparam int PW  = NW + PIW + FW;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          phase_start = 1'b0;
    logic          phase_end = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NW-1:0] in_dest = '0;
    logic [PIW-1:0] in_pid = '0;
    logic [FW-1:0] in_force = '0;
    logic [PW-1:0] pkt_out;
    logic          pkt_valid;
    logic          ring_ready = 1'b0;
    logic          drain_done;
    logic          busy;
    logic [15:0]   sent_count;

    int checks = 0;
    int failures = 0;

    ring_injector #(
        .NUM_CELLS(64),
        .DATA_WIDTH(32),
        .PARTICLE_ID_WIDTH(7),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .phase_start(phase_start),
        .phase_end(phase_end),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_dest(in_dest),
        .in_pid(in_pid),
        .in_force(in_force),
        .pkt_out(pkt_out),
        .pkt_valid(pkt_valid),
        .ring_ready(ring_ready),
        .drain_done(drain_done),
        .busy(busy),
        .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pk(
        input logic [NW-1:0] d,
        input logic [PIW-1:0] p,
        input logic [FW-1:0] f
    );
        return {d, p, f};
    endfunction

    function automatic logic [FW-1:0] mkf(input int i);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = 32'(i * 7 + 1);
        b = 32'(i) ^ 32'hA5A5_0000;
        c = 32'hDEAD_0000 + 32'(i);
        return {c, b, a};
    endfunction

    task automatic chk(
        input string name,
        input logic [127:0] act,
        input logic [127:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    // Reference model: packet queue plus phase (0 idle,1 collect,
    // 2 drain,3 done) and sent counter.
    logic [PW-1:0] m_q [$];
    int            m_phase = 0;
    logic [15:0]   m_sent = '0;
    bit            m_ok = 0;

    always @(negedge clk) begin
        int n;
        bit acc;
        bit take;
        logic [PW-1:0] head;
        n = m_q.size();
        head = (n > 0) ? m_q[0] : '0;
        if (m_ok) begin
            chk("in_ready", 128'(in_ready),
                128'(m_phase == 1 && n < DEPTH));
            chk("pkt_valid", 128'(pkt_valid), 128'(n > 0));
            chk("pkt_out", 128'(pkt_out), 128'(head));
            chk("busy", 128'(busy), 128'(m_phase != 0));
            chk("drain_done", 128'(drain_done),
                128'(m_phase == 3));
            chk("sent_count", 128'(sent_count), 128'(m_sent));
        end
        acc  = in_valid && m_phase == 1 && n < DEPTH;
        take = (n > 0) && ring_ready;
        if (rst) begin
            m_q.delete();
            m_phase = 0;
            m_sent = '0;
            m_ok = 1;
        end else begin
            if (take) begin
                void'(m_q.pop_front());
                if (m_sent != 16'hFFFF) m_sent = m_sent + 16'd1;
            end
            if (acc) m_q.push_back(pk(in_dest, in_pid, in_force));
            case (m_phase)
                0: if (phase_start) begin
                    m_phase = 1;
                    m_sent = '0;
                end
                1: if (phase_end) m_phase = 2;
                2: if (n == 0) m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push(
        input logic [NW-1:0] d,
        input logic [PIW-1:0] p,
        input logic [FW-1:0] f
    );
        int n;
        in_valid = 1'b1;
        in_dest = d;
        in_pid = p;
        in_force = f;
        n = 0;
        while (!in_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=0 required=1");
        end else begin
            tick(1);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        phase_start = 1'b1;
        tick(1);
        phase_start = 1'b0;
    endtask

    task automatic pulse_end();
        phase_end = 1'b1;
        tick(1);
        phase_end = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] f0;
        logic [PW-1:0] first;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("rst_pkt_valid", 128'(pkt_valid), 128'd0);
        chk("rst_pkt_out", 128'(pkt_out), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_sent", 128'(sent_count), 128'd0);

        // Three records, ring always ready.
        ring_ready = 1'b1;
        pulse_start();
        push(6'd5, 7'd1, mkf(1));
        chk("t1_out0", 128'(pkt_out), 128'(pk(6'd5, 7'd1, mkf(1))));
        push(6'd0, 7'd2, mkf(2));
        chk("t1_out1", 128'(pkt_out), 128'(pk(6'd0, 7'd2, mkf(2))));
        push(6'd63, 7'd127, mkf(3));
        chk("t1_out2", 128'(pkt_out),
            128'(pk(6'd63, 7'd127, mkf(3))));
        tick(2);
        chk("t1_sent", 128'(sent_count), 128'd3);
        pulse_start();
        chk("t1_restart_ignored", 128'(sent_count), 128'd3);

        // Fill to full with the ring stalled.
        ring_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(6'(i * 3), 7'(i + 10), mkf(i + 100));
        end
        f0 = mkf(100);
        first = pk(6'd0, 7'd10, f0);
        in_valid = 1'b1;
        in_dest = 6'(48);
        in_pid = 7'(26);
        in_force = mkf(116);
        tick(2);
        chk("t2_full_ready", 128'(in_ready), 128'd0);
        chk("t2_head_hold", 128'(pkt_out), 128'(first));

        // Release; 17th enters, everything drains across wrap.
        ring_ready = 1'b1;
        push(6'(48), 7'(26), mkf(116));
        tick(20);
        chk("t3_sent", 128'(sent_count), 128'd20);
        chk("t3_empty", 128'(pkt_valid), 128'd0);

        // Four buffered, phase_end while stalled, then release.
        ring_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(6'd63, 7'(i), mkf(i + 200));
        end
        pulse_end();
        in_valid = 1'b1;
        tick(2);
        chk("t4_drain_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b0;
        ring_ready = 1'b1;
        tick(4);
        chk("t4_dd_early", 128'(drain_done), 128'd0);
        chk("t4_busy_mid", 128'(busy), 128'd1);
        tick(1);
        chk("t4_dd_pulse", 128'(drain_done), 128'd1);
        chk("t4_sent", 128'(sent_count), 128'd24);
        tick(1);
        chk("t4_dd_off", 128'(drain_done), 128'd0);
        chk("t4_busy_off", 128'(busy), 128'd0);
        chk("t4_sent_hold", 128'(sent_count), 128'd24);

        // Empty phase.
        pulse_start();
        chk("t5_sent_clr", 128'(sent_count), 128'd0);
        pulse_end();
        chk("t5_dd_wait", 128'(drain_done), 128'd0);
        tick(1);
        chk("t5_dd", 128'(drain_done), 128'd1);
        tick(1);
        chk("t5_idle", 128'(busy), 128'd0);

        // Coincident start and end: end is ignored.
        phase_start = 1'b1;
        phase_end = 1'b1;
        tick(1);
        phase_start = 1'b0;
        phase_end = 1'b0;
        tick(3);
        chk("t5b_active", 128'(in_ready), 128'd1);
        pulse_end();
        tick(3);
        chk("t5b_idle", 128'(busy), 128'd0);

        // Reset mid-phase discards buffered packets.
        pulse_start();
        ring_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(6'(i + 1), 7'(i + 50), mkf(i + 300));
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_valid", 128'(pkt_valid), 128'd0);
        chk("t6_out", 128'(pkt_out), 128'd0);
        chk("t6_busy", 128'(busy), 128'd0);
        pulse_start();
        ring_ready = 1'b1;
        tick(3);
        chk("t6_no_stale", 128'(pkt_valid), 128'd0);
        chk("t6_sent", 128'(sent_count), 128'd0);
        push(6'd9, 7'd99, mkf(400));
        chk("t6_fresh", 128'(pkt_out),
            128'(pk(6'd9, 7'd99, mkf(400))));
        tick(2);
        chk("t6_sent1", 128'(sent_count), 128'd1);
        pulse_end();
        tick(4);
        chk("t6_end_idle", 128'(busy), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
